pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush controller for the five-stage pipeline. It turns cache-miss, load-use and branch-redirect events into per-register stall and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also tracks outstanding misses across overlapping events, and discards a wrong-path instruction fetched during an I-cache refill. It sits beside the datapath and drives the `stall_*` and `flush_*` inputs of every pipeline register.

## Interface
Parameters:
- `REG_W`, 5, register-specifier width.
- `CNT_W`, 32, perf counter width (only with the configuration macro).

Ports:
- `clk  in  1`  pipeline clock.
- `rst_n  in  1`  reset, **asynchronous, active-low**.
- `icache_miss  in  1`  level: current IF fetch misses. Deasserts in the cycle the word is valid.
- `dcache_miss  in  1`  level: current MEM access misses. Deasserts when the access completes.
- `branch_taken  in  1`  EX-stage redirect (branch/jump taken).
- `ex_memread  in  1`  instruction in EX is a load.
- `ex_rt  in  REG_W`  load destination in EX.
- `id_rs, id_rt  in  REG_W`  source specifiers of the instruction in ID.
- `stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb  out  1`  hold the respective register.
- `flush_if_id, flush_id_ex  out  1`  load a bubble (honoured only when the matching stall is 0).
- `perf_istall, perf_dstall, perf_loaduse  out  CNT_W`  present only with `PIPELINE_CTRL_PERF_EN`.

## Operation
- `load_use = ex_memread & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt)`.
- FSM states: RUN, IWAIT, DWAIT, plus a `discard` flag register. All outputs are Mealy functions of state, flag and current inputs. Any output not listed for a case is 0.
- **RUN**, evaluated in priority order:
  - `dcache_miss`: all five stalls 1, no flush, go to DWAIT. The branch is re-evaluated after the freeze.
  - `branch_taken`: `flush_if_id=1`, `flush_id_ex=1`, `load_use` ignored. If `icache_miss` is also set, also `stall_pc=1`, set `discard`, go to IWAIT.
  - `load_use`: `stall_pc=1`, `stall_if_id=1`, `flush_id_ex=1`. If `icache_miss` is also set, go to IWAIT.
  - `icache_miss`: `stall_pc=1`, `flush_if_id=1`, go to IWAIT.
- **IWAIT** (`icache_miss` high):
  - Outputs `stall_pc=1`, `flush_if_id=1`.
  - `load_use` additionally gives `stall_if_id=1` and `flush_id_ex=1`.
  - `branch_taken` gives `flush_id_ex=1` and sets `discard`.
  - `dcache_miss` overrides everything: all stalls 1, flushes 0, go to DWAIT; `discard` is kept.
- **IWAIT exit** (`icache_miss` low): `stall_pc=0`; go to RUN.
  - If `discard`: `flush_if_id=1` (the returned wrong-path word is dropped) and clear `discard`.
  - Otherwise: `flush_if_id=0`, so the word enters ID.
  - In the same cycle `load_use` and `branch_taken` apply with RUN rules.
- **DWAIT**: all stalls 1, flushes 0, `branch_taken` and `load_use` ignored. When `dcache_miss` goes low, apply RUN rules that cycle.

## Timing
- Stall/flush outputs take effect in the same cycle as the triggering input (zero-latency combinational path). State and flag update at the next rising edge.
- While `rst_n` is low: state RUN, `discard=0`, all stall and flush outputs 0, perf counters 0. Reset asserted mid-miss aborts the miss tracking immediately.
- A load-use stall lasts exactly 1 cycle when no miss is outstanding. A branch flush lasts 1 cycle.
- `dcache_miss` and `icache_miss` asserted together in RUN: DWAIT first. On exit, if `icache_miss` is still high, go to IWAIT next cycle.

## Configuration
- `PIPELINE_CTRL_PERF_EN` defined: three `CNT_W` saturating counters are built.
  - `perf_istall` counts cycles in IWAIT.
  - `perf_dstall` counts cycles in DWAIT.
  - `perf_loaduse` counts load-use stall cycles.
  - Counters hold at all-ones and reset to 0.
- Not defined: the counters and their ports are absent. Control behaviour is identical either way.

## Structure
- Package `pipeline_ctrl_pkg`: state enum (RUN/IWAIT/DWAIT) and the `REG_W` and `CNT_W` defaults.
- Sub-module `hazard_detect`: combinational `load_use` compare. It is reused later for forwarding checks.

## Test plan
- **Load-use:** RUN, `ex_memread=1`, `ex_rt=5`, `id_rs=5` for 1 cycle.
  - Expect `stall_pc=stall_if_id=flush_id_ex=1` for exactly 1 cycle; other stalls 0.
- **I-miss:** `icache_miss` high 4 cycles.
  - Expect `stall_pc=1` and `flush_if_id=1` for 4 cycles.
  - Cycle 5: both 0, state RUN, `perf_istall=4`.
- **Branch during I-miss:** `icache_miss` high cycles 0–5, `branch_taken` at cycle 2.
  - Expect `flush_id_ex=1` at cycle 2.
  - At cycle 6: `flush_if_id=1`, `stall_pc=0`, `discard` cleared.
- **Nested misses:** I-miss starts at cycle 0; `dcache_miss` high cycles 2–4.
  - Cycles 2–4: all stalls 1, flushes 0.
  - Cycle 5: back to IWAIT behaviour while `icache_miss` remains high.
- **Simultaneous events:** `dcache_miss` and `branch_taken` in the same cycle.
  - Expect a freeze with no flush.
  - On the cycle `dcache_miss` drops, `flush_if_id=flush_id_ex=1`.
- **Reset mid-miss:** assert `rst_n=0` during IWAIT.
  - Expect all outputs 0 immediately (asynchronous).
  - After release with `icache_miss=0`: RUN, outputs 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

    localparam int REG_W_DEF = 5;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IWAIT = 2'd1,
        ST_DWAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic stall_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
    } ctrl_t;

    // Whole-pipe hold used while a data-cache miss is outstanding.
    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c              = '0;
        c.stall_pc     = 1'b1;
        c.stall_if_id  = 1'b1;
        c.stall_id_ex  = 1'b1;
        c.stall_ex_mem = 1'b1;
        c.stall_mem_wb = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources in ID.
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             load_use
);

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    always_comb begin
        load_use = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline: cache misses, load-use, branch redirect.
// Optional saturating perf counters are built when PIPELINE_CTRL_PERF_EN is defined.
//
// state | meaning
// RUN   | no miss outstanding, events handled directly
// IWAIT | I-cache refill in progress, PC held, IF/ID fed bubbles
// DWAIT | D-cache miss in progress, whole pipeline frozen
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             icache_miss,
    input  logic             dcache_miss,
    input  logic             branch_taken,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             stall_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_istall,
    output logic [CNT_W-1:0] perf_dstall,
    output logic [CNT_W-1:0] perf_loaduse
`endif
);

    state_t state_q, state_d;
    logic   discard_q, discard_d;
    logic   load_use;
    logic   run_rules;
    logic   lu_stall;
    ctrl_t  ctrl;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .load_use   (load_use)
    );

    // Cycles where the plain RUN priority rules decide outputs and next state:
    // RUN itself, the cycle a refill completes, and the cycle a D-miss clears.
    always_comb begin
        run_rules = (state_q == ST_RUN)
                 || ((state_q == ST_IWAIT) && !icache_miss)
                 || ((state_q == ST_DWAIT) && !dcache_miss);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        if (run_rules) begin
            if (dcache_miss) begin
                state_d = ST_DWAIT;
            end else if (icache_miss) begin
                state_d = ST_IWAIT;
                if (branch_taken) discard_d = 1'b1;
            end else begin
                // Refill word has arrived (or none pending): any discard is consumed now.
                state_d   = ST_RUN;
                discard_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                ST_IWAIT: begin
                    if (dcache_miss)       state_d   = ST_DWAIT;
                    else if (branch_taken) discard_d = 1'b1;
                end
                ST_DWAIT: state_d = ST_DWAIT;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        ctrl     = '0;
        lu_stall = 1'b0;
        if (run_rules) begin
            if (dcache_miss) begin
                ctrl = ctrl_freeze();
            end else if (branch_taken) begin
                ctrl.flush_if_id = 1'b1;
                ctrl.flush_id_ex = 1'b1;
                ctrl.stall_pc    = icache_miss;
            end else if (load_use) begin
                ctrl.stall_pc    = 1'b1;
                ctrl.stall_if_id = 1'b1;
                ctrl.flush_id_ex = 1'b1;
                lu_stall         = 1'b1;
            end else if (icache_miss) begin
                ctrl.stall_pc    = 1'b1;
                ctrl.flush_if_id = 1'b1;
            end
            // A wrong-path word returning from the refill is dropped on its way into ID.
            if (discard_q && !dcache_miss && !icache_miss) ctrl.flush_if_id = 1'b1;
        end else if (state_q == ST_IWAIT) begin
            if (dcache_miss) begin
                ctrl = ctrl_freeze();
            end else begin
                ctrl.stall_pc    = 1'b1;
                ctrl.flush_if_id = 1'b1;
                if (branch_taken) begin
                    ctrl.flush_id_ex = 1'b1;
                end else if (load_use) begin
                    ctrl.stall_if_id = 1'b1;
                    ctrl.flush_id_ex = 1'b1;
                    lu_stall         = 1'b1;
                end
            end
        end else if (state_q == ST_DWAIT) begin
            ctrl = ctrl_freeze();
        end
        if (!rst_n) begin
            ctrl     = '0;
            lu_stall = 1'b0;
        end
    end

    always_comb begin
        stall_pc     = ctrl.stall_pc;
        stall_if_id  = ctrl.stall_if_id;
        stall_id_ex  = ctrl.stall_id_ex;
        stall_ex_mem = ctrl.stall_ex_mem;
        stall_mem_wb = ctrl.stall_mem_wb;
        flush_if_id  = ctrl.flush_if_id;
        flush_id_ex  = ctrl.flush_id_ex;
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_istall_q,  perf_istall_d;
    logic [CNT_W-1:0] perf_dstall_q,  perf_dstall_d;
    logic [CNT_W-1:0] perf_loaduse_q, perf_loaduse_d;

    // Counters saturate at all-ones rather than wrapping.
    always_comb begin
        perf_istall_d  = perf_istall_q;
        perf_dstall_d  = perf_dstall_q;
        perf_loaduse_d = perf_loaduse_q;
        if ((state_q == ST_IWAIT) && !(&perf_istall_q))  perf_istall_d  = perf_istall_q + 1'b1;
        if ((state_q == ST_DWAIT) && !(&perf_dstall_q))  perf_dstall_d  = perf_dstall_q + 1'b1;
        if (lu_stall && !(&perf_loaduse_q))              perf_loaduse_d = perf_loaduse_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_istall_q  <= '0;
            perf_dstall_q  <= '0;
            perf_loaduse_q <= '0;
        end else begin
            perf_istall_q  <= perf_istall_d;
            perf_dstall_q  <= perf_dstall_d;
            perf_loaduse_q <= perf_loaduse_d;
        end
    end

    always_comb begin
        perf_istall  = perf_istall_q;
        perf_dstall  = perf_dstall_q;
        perf_loaduse = perf_loaduse_q;
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (perf checks only with PIPELINE_CTRL_PERF_EN).
module tb_pipeline_ctrl;

    localparam int REG_W = 5;

    // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, flush_if_id, flush_id_ex}
    localparam logic [6:0] O_NONE     = 7'b0000000;
    localparam logic [6:0] O_FREEZE   = 7'b1111100;
    localparam logic [6:0] O_LU       = 7'b1100001;
    localparam logic [6:0] O_BR       = 7'b0000011;
    localparam logic [6:0] O_IMISS    = 7'b1000010;
    localparam logic [6:0] O_IMISS_BR = 7'b1000011;
    localparam logic [6:0] O_DISCARD  = 7'b0000010;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             icache_miss, dcache_miss, branch_taken, ex_memread;
    logic [REG_W-1:0] ex_rt, id_rs, id_rt;
    logic             stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic             flush_if_id, flush_id_ex;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0]      perf_istall, perf_dstall, perf_loaduse;
`endif
    logic [6:0]       outs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.REG_W(REG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .icache_miss  (icache_miss),
        .dcache_miss  (dcache_miss),
        .branch_taken (branch_taken),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .stall_pc     (stall_pc),
        .stall_if_id  (stall_if_id),
        .stall_id_ex  (stall_id_ex),
        .stall_ex_mem (stall_ex_mem),
        .stall_mem_wb (stall_mem_wb),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .perf_istall  (perf_istall),
        .perf_dstall  (perf_dstall),
        .perf_loaduse (perf_loaduse)
`endif
    );

    assign outs = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                   flush_if_id, flush_id_ex};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pipeline cycle: drive inputs at the falling edge, check combinational outputs 1 ns later.
    task automatic step(input string tag, input logic ic, input logic dc, input logic br,
                        input logic mr, input logic [REG_W-1:0] ert, input logic [REG_W-1:0] irs,
                        input logic [REG_W-1:0] irt, input logic [6:0] exp);
        @(negedge clk);
        icache_miss  = ic;
        dcache_miss  = dc;
        branch_taken = br;
        ex_memread   = mr;
        ex_rt        = ert;
        id_rs        = irs;
        id_rt        = irt;
        #1;
        check(tag, {25'd0, outs}, {25'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        icache_miss  = 1'b1;
        dcache_miss  = 1'b1;
        branch_taken = 1'b1;
        ex_memread   = 1'b0;
        ex_rt        = '0;
        id_rs        = '0;
        id_rt        = '0;
        #12;
        check("reset_outputs", {25'd0, outs}, {25'd0, O_NONE});
`ifdef PIPELINE_CTRL_PERF_EN
        check("reset_perf_istall", perf_istall, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step("idle", 0, 0, 0, 0, 0, 0, 0, O_NONE);

        // Load-use hazards
        step("lu_rs",       0, 0, 0, 1, 5, 5, 0, O_LU);
        step("lu_done",     0, 0, 0, 0, 0, 0, 0, O_NONE);
        step("lu_r0",       0, 0, 0, 1, 0, 0, 0, O_NONE);
        step("lu_rt",       0, 0, 0, 1, 7, 3, 7, O_LU);
        step("lu_noload",   0, 0, 0, 0, 7, 7, 7, O_NONE);
        step("lu_nomatch",  0, 0, 0, 1, 7, 3, 4, O_NONE);

        // I-miss for 4 cycles
        for (int i = 0; i < 4; i++) step("imiss_hold", 1, 0, 0, 0, 0, 0, 0, O_IMISS);
        step("imiss_exit",  0, 0, 0, 0, 0, 0, 0, O_NONE);
        step("imiss_after", 0, 0, 0, 0, 0, 0, 0, O_NONE);
`ifdef PIPELINE_CTRL_PERF_EN
        check("perf_istall", perf_istall, 32'd4);
        check("perf_loaduse", perf_loaduse, 32'd2);
`endif

        // Branch during I-miss: wrong-path word dropped on exit
        step("bri_c0", 1, 0, 0, 0, 0, 0, 0, O_IMISS);
        step("bri_c1", 1, 0, 0, 0, 0, 0, 0, O_IMISS);
        step("bri_c2", 1, 0, 1, 0, 0, 0, 0, O_IMISS_BR);
        for (int i = 3; i < 6; i++) step("bri_hold", 1, 0, 0, 0, 0, 0, 0, O_IMISS);
        step("bri_exit",  0, 0, 0, 0, 0, 0, 0, O_DISCARD);
        step("bri_clear", 0, 0, 0, 0, 0, 0, 0, O_NONE);

        // Nested D-miss inside an I-miss
        step("nest_c0", 1, 0, 0, 0, 0, 0, 0, O_IMISS);
        step("nest_c1", 1, 0, 0, 0, 0, 0, 0, O_IMISS);
        for (int i = 2; i < 5; i++) step("nest_freeze", 1, 1, 0, 0, 0, 0, 0, O_FREEZE);
        step("nest_c5", 1, 0, 0, 0, 0, 0, 0, O_IMISS);
        step("nest_c6", 1, 0, 0, 0, 0, 0, 0, O_IMISS);
        step("nest_exit", 0, 0, 0, 0, 0, 0, 0, O_NONE);

        // D-miss and branch together; load-use ignored while frozen
        step("sim_c0",   0, 1, 1, 0, 0, 0, 0, O_FREEZE);
        step("sim_c1",   0, 1, 1, 1, 5, 5, 0, O_FREEZE);
        step("sim_drop", 0, 0, 1, 1, 5, 5, 0, O_BR);
        step("sim_idle", 0, 0, 0, 0, 0, 0, 0, O_NONE);
`ifdef PIPELINE_CTRL_PERF_EN
        check("perf_dstall", perf_dstall, 32'd5);
        check("perf_loaduse_frz", perf_loaduse, 32'd2);
`endif

        // Branch with I-miss in RUN, then load-use with I-miss
        step("brim_c0",  1, 0, 1, 0, 0, 0, 0, O_IMISS_BR);
        step("brim_ex",  0, 0, 0, 0, 0, 0, 0, O_DISCARD);
        step("luim_c0",  1, 0, 0, 1, 6, 0, 6, O_LU);
        step("luim_c1",  1, 0, 0, 0, 0, 0, 0, O_IMISS);
        step("luim_ex",  0, 0, 0, 0, 0, 0, 0, O_NONE);

        // Reset mid-miss
        step("rst_c0", 1, 0, 0, 0, 0, 0, 0, O_IMISS);
        step("rst_c1", 1, 0, 0, 0, 0, 0, 0, O_IMISS);
        rst_n = 1'b0;
        #1;
        check("rst_async", {25'd0, outs}, {25'd0, O_NONE});
`ifdef PIPELINE_CTRL_PERF_EN
        check("rst_perf_istall", perf_istall, 32'd0);
`endif
        @(negedge clk);
        icache_miss = 1'b0;
        rst_n       = 1'b1;
        #1;
        check("rst_release", {25'd0, outs}, {25'd0, O_NONE});
        step("rst_run", 0, 0, 0, 0, 0, 0, 0, O_NONE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
